// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control types for the hazard controller: forward selects,
// branch kinds, write-back value sources and the stall/flush bundle.
package hazard_ctrl_pkg;

  typedef logic [4:0] regidx_t;

  typedef enum logic [2:0] {
    HAZ_DEFAULT,
    HAZ_ALU_RES_E,
    HAZ_ALU_RES_M,
    HAZ_MEM_RES_M,
    HAZ_RES_W
  } hazard_forward_t;

  typedef enum logic [3:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_BLEZ,
    BR_BGTZ,
    BR_BLTZ,
    BR_BGEZ,
    BR_J,
    BR_JAL,
    BR_JR,
    BR_JALR
  } ctrl_branch_t;

  typedef enum logic [2:0] {
    VAL_ALU_RES,
    VAL_MEM,
    VAL_PC8,
    VAL_HI,
    VAL_LO
  } ctrl_reg_val_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } hazard_stall_t;

  localparam int MUL_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT = 33;

  // A used, non-zero source register that matches a write destination.
  function automatic logic src_hit(input logic used, input regidx_t idx, input regidx_t dst);
    return used && (idx != '0) && (idx == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller. The slave modport is the
// controller; the master modport is the pipeline that feeds it.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int PERF_W = 32
) ();

  ctrl_branch_t     branch_d;
  hazard_forward_t  forward_rs_d;
  hazard_forward_t  forward_rt_d;
  regidx_t          rs_d;
  regidx_t          rt_d;
  logic             rs_used_d;
  logic             rt_used_d;
  logic             reg_write_en_e;
  logic             reg_write_en_m;
  regidx_t          reg_write_dst_e;
  regidx_t          reg_write_dst_m;
  ctrl_reg_val_t    reg_write_val_e;
  ctrl_reg_val_t    reg_write_val_m;
  logic             muldiv_start_e;
  logic             muldiv_is_div_e;
  logic             hilo_read_e;
  logic             ireq_pending;
  logic             idata_ok;
  logic             dreq_valid_m;
  logic             ddata_ok;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_m, flush_w;
  logic             muldiv_busy;
  logic [PERF_W-1:0] perf_stall_cnt;

  modport master (
    output branch_d, forward_rs_d, forward_rt_d, rs_d, rt_d, rs_used_d, rt_used_d,
    output reg_write_en_e, reg_write_en_m, reg_write_dst_e, reg_write_dst_m,
    output reg_write_val_e, reg_write_val_m, muldiv_start_e, muldiv_is_div_e, hilo_read_e,
    output ireq_pending, idata_ok, dreq_valid_m, ddata_ok,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
    input  muldiv_busy, perf_stall_cnt
  );

  modport slave (
    input  branch_d, forward_rs_d, forward_rt_d, rs_d, rt_d, rs_used_d, rt_used_d,
    input  reg_write_en_e, reg_write_en_m, reg_write_dst_e, reg_write_dst_m,
    input  reg_write_val_e, reg_write_val_m, muldiv_start_e, muldiv_is_div_e, hilo_read_e,
    input  ireq_pending, idata_ok, dreq_valid_m, ddata_ok,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
    output muldiv_busy, perf_stall_cnt
  );

endinterface

// File: rtl/hazard_ctrl_muldiv_tracker.sv
// HI/LO occupancy tracker: a down-counter loaded when a mult/div issue is
// accepted, reporting busy and the mult/div wait hazard.
module hazard_ctrl_muldiv_tracker
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic is_div,
  input  logic hilo_read,
  input  logic dmem_wait,
  output logic busy,
  output logic md_wait
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             accept;

  // A new op (or HI/LO read) must wait while the previous result is pending;
  // a start on the last busy cycle is therefore deferred by one cycle.
  assign busy    = (cnt != '0);
  assign md_wait = busy & (hilo_read | start);
  assign accept  = start & ~dmem_wait & ~md_wait;

  // Load on an accepted issue, otherwise count down to zero and hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
    end else if (busy) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller for the 5-stage MIPS core.
// Optional build macro: BRANCH_E_FWD_EN -- when defined, a branch operand
// produced by the E-stage ALU is forwarded to the compare instead of stalling.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int PERF_W     = 32
) (
  input  logic          clk,
  input  logic          resetn,
  hazard_ctrl_if.slave  bus
);

  logic          dmem_wait, md_wait, imem_wait, load_use;
  logic          is_br, lu_e_mem, lu_m_mem, lu_e_other, lu_e_alu;
  logic          busy;
  hazard_stall_t st;
  logic [PERF_W-1:0] perf_q;

  hazard_ctrl_muldiv_tracker #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_tracker (
    .clk       (clk),
    .resetn    (resetn),
    .start     (bus.muldiv_start_e),
    .is_div    (bus.muldiv_is_div_e),
    .hilo_read (bus.hilo_read_e),
    .dmem_wait (dmem_wait),
    .busy      (busy),
    .md_wait   (md_wait)
  );

  assign dmem_wait = bus.dreq_valid_m & ~bus.ddata_ok;
  assign imem_wait = bus.ireq_pending & ~bus.idata_ok;
  assign is_br     = (bus.branch_d == BR_BEQ) || (bus.branch_d == BR_BNE) ||
                     (bus.branch_d == BR_JR);

  // Load-use style hazards: a load in E feeding any consumer, and branch
  // compares in D that cannot get their operand from the forwarding network.
  always_comb begin
    lu_e_mem   = bus.reg_write_en_e && (bus.reg_write_val_e == VAL_MEM) &&
                 (src_hit(bus.rs_used_d, bus.rs_d, bus.reg_write_dst_e) ||
                  src_hit(bus.rt_used_d, bus.rt_d, bus.reg_write_dst_e));
    lu_m_mem   = is_br && bus.reg_write_en_m && (bus.reg_write_val_m == VAL_MEM) &&
                 ((src_hit(bus.rs_used_d, bus.rs_d, bus.reg_write_dst_m) &&
                   (bus.forward_rs_d == HAZ_DEFAULT)) ||
                  (src_hit(bus.rt_used_d, bus.rt_d, bus.reg_write_dst_m) &&
                   (bus.forward_rt_d == HAZ_DEFAULT)));
    lu_e_other = is_br && bus.reg_write_en_e &&
                 (bus.reg_write_val_e != VAL_ALU_RES) && (bus.reg_write_val_e != VAL_MEM) &&
                 ((src_hit(bus.rs_used_d, bus.rs_d, bus.reg_write_dst_e) &&
                   (bus.forward_rs_d == HAZ_DEFAULT)) ||
                  (src_hit(bus.rt_used_d, bus.rt_d, bus.reg_write_dst_e) &&
                   (bus.forward_rt_d == HAZ_DEFAULT)));
`ifdef BRANCH_E_FWD_EN
    lu_e_alu   = 1'b0;
`else
    // Keep the E-ALU result off the branch-compare path: wait one cycle
    // until the operand is available from M.
    lu_e_alu   = is_br &&
                 ((bus.rs_used_d && (bus.rs_d != '0) && (bus.forward_rs_d == HAZ_ALU_RES_E)) ||
                  (bus.rt_used_d && (bus.rt_d != '0) && (bus.forward_rt_d == HAZ_ALU_RES_E)));
`endif
    load_use   = lu_e_mem | lu_m_mem | lu_e_other | lu_e_alu;
  end

  // Only the highest-priority hazard drives the stage controls.
  always_comb begin
    st = '0;
    if (!resetn) begin
      st = '0;
    end else if (dmem_wait) begin
      st.stall_f = 1'b1;
      st.stall_d = 1'b1;
      st.stall_e = 1'b1;
      st.stall_m = 1'b1;
      st.flush_w = 1'b1;
    end else if (md_wait) begin
      st.stall_f = 1'b1;
      st.stall_d = 1'b1;
      st.stall_e = 1'b1;
      st.flush_m = 1'b1;
    end else if (load_use) begin
      st.stall_f = 1'b1;
      st.stall_d = 1'b1;
      st.flush_e = 1'b1;
    end else if (imem_wait) begin
      st.stall_f = 1'b1;
      st.flush_d = 1'b1;
    end
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_q <= '0;
    end else if (st.stall_f && (perf_q != '1)) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign bus.stall_f        = st.stall_f;
  assign bus.stall_d        = st.stall_d;
  assign bus.stall_e        = st.stall_e;
  assign bus.stall_m        = st.stall_m;
  assign bus.flush_d        = st.flush_d;
  assign bus.flush_e        = st.flush_e;
  assign bus.flush_m        = st.flush_m;
  assign bus.flush_w        = st.flush_w;
  assign bus.muldiv_busy    = busy;
  assign bus.perf_stall_cnt = perf_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline stall/flush controller for the 5-stage MIPS core.
- Sits directly downstream of the two decode-stage forwarding evaluators (rs and rt). Consumes their forward selects plus E/M/W write-back info, memory handshake status and mult/div activity.
- Produces per-stage stall/flush controls.
- Owns the sequential mult/div busy tracker and a stall-cycle performance counter.

Parameters:
MUL_CYCLES, 5, cycles a multiply occupies HI/LO after issue
DIV_CYCLES, 33, cycles a divide occupies HI/LO after issue
PERF_W, 32, width of stall-cycle counter

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
branch_d  in  ctrl_branch_t  branch/jump kind of D instruction
forward_rs_d, forward_rt_d  in  hazard_forward_t  D-stage forward selects from the forwarding evaluators
rs_d, rt_d  in  regidx_t  D-stage source indices
rs_used_d, rt_used_d  in  1  D instruction reads rs/rt
reg_write_en_e, reg_write_en_m  in  1  write enables
reg_write_dst_e, reg_write_dst_m  in  regidx_t  write destinations
reg_write_val_e, reg_write_val_m  in  ctrl_reg_val_t  result source (VAL_ALU_RES, VAL_MEM, ...)
muldiv_start_e  in  1  E instruction issues mult/div
muldiv_is_div_e  in  1  issued op is a divide
hilo_read_e  in  1  E instruction reads HI/LO (mfhi/mflo)
ireq_pending  in  1  fetch request outstanding
idata_ok  in  1  fetch data returned this cycle
dreq_valid_m  in  1  M stage memory access active
ddata_ok  in  1  data memory completed this cycle
stall_f, stall_d, stall_e, stall_m  out  1  hold stage register
flush_d, flush_e, flush_m, flush_w  out  1  insert bubble into stage register
muldiv_busy  out  1  HI/LO tracker counting
perf_stall_cnt  out  PERF_W  total cycles with stall_f asserted

Behaviour:
- Outputs are combinational from inputs and state. During reset: all stall/flush 0, muldiv_busy 0, perf_stall_cnt 0.
- Hazard terms, evaluated in priority order:
  - dmem_wait = dreq_valid_m & ~ddata_ok
  - md_wait = muldiv_busy & (hilo_read_e | muldiv_start_e)
  - load_use
  - imem_wait = ireq_pending & ~idata_ok
- Output effects; only the highest active term applies:
  - dmem_wait: stall_f/d/e/m=1, flush_w=1.
  - md_wait: stall_f/d/e=1, flush_m=1.
  - load_use: stall_f/d=1, flush_e=1.
  - imem_wait alone: stall_f=1, flush_d=1.
  - none active: all 0.
- load_use is asserted on any of:
  - (a) reg_write_en_e & reg_write_val_e==VAL_MEM & reg_write_dst_e!=0 & dst matches a used source (rs_d with rs_used_d, or rt_d with rt_used_d).
  - (b) branch_d in {BR_BEQ,BR_BNE,BR_JR} & reg_write_en_m & reg_write_val_m==VAL_MEM & reg_write_dst_m!=0 & dst matches a used source whose forward select is HAZ_DEFAULT.
  - (c) branch_d in {BR_BEQ,BR_BNE,BR_JR}, with a used source whose E-stage write is non-ALU (not VAL_ALU_RES, not VAL_MEM) and whose forward select is HAZ_DEFAULT.
- Register index 0 never causes a hazard.
- Mult/div tracker:
  - cnt is a down-counter of width clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
  - Load: when muldiv_start_e & ~dmem_wait & ~md_wait, cnt loads DIV_CYCLES if muldiv_is_div_e, else MUL_CYCLES.
  - Otherwise: if cnt!=0, cnt decrements; if cnt==0, it holds.
  - muldiv_busy = (cnt!=0).
  - A start accepted on the cycle cnt reaches 1 is blocked by md_wait. It is accepted the next cycle.
- perf_stall_cnt increments when stall_f=1 and saturates at all-ones.
- Reset asserted mid-operation clears cnt and perf_stall_cnt immediately, with no wait for a clock edge.

Optional Feature:
- Macro: BRANCH_E_FWD_EN.
- Defined: a branch operand with forward select HAZ_ALU_RES_E is forwarded and no stall results.
- Undefined: a D-stage branch/JR whose used source has forward select HAZ_ALU_RES_E raises load_use for one cycle (stall_f/d, flush_e). This relieves the E-ALU-to-branch-compare path. The next cycle, the select becomes HAZ_ALU_RES_M and the branch proceeds.

Decomposition:
- The shared control package already holds hazard_forward_t, ctrl_branch_t and ctrl_reg_val_t.
- Add to the package: the hazard_stall_t packed struct (the four stalls and four flushes) and the MUL_CYCLES/DIV_CYCLES defaults.
- One sub-module: muldiv_tracker (counter, busy, start acceptance).

Test Plan:
- lw $2 in E, D reads $2 via rs_used_d -> stall_f=stall_d=flush_e=1 for exactly 1 cycle. Same with dst=$0 -> no stall.
- beq in D reading $3; lw $3 in M with forward select HAZ_DEFAULT -> load_use=1 one cycle. Next cycle select HAZ_RES_W -> no stall.
- mult issued (muldiv_start_e, is_div=0), mfhi enters E 2 cycles later -> md_wait stalls F/D/E with flush_m until muldiv_busy falls exactly 5 cycles after issue. div -> 33 cycles.
- dreq_valid_m=1, ddata_ok low 3 cycles, concurrent load_use -> stall_f/d/e/m + flush_w for 3 cycles, flush_e never asserted. Afterwards load_use applies 1 cycle.
- resetn pulsed low while cnt=20 -> muldiv_busy=0 and perf_stall_cnt=0 asynchronously. Outputs all 0 during reset.
- Branch with forward select HAZ_ALU_RES_E -> 1-cycle stall without BRANCH_E_FWD_EN, none with it.
